// File: rtl/conv_result_reader.sv
// Result read-out for the convolution engine: walks every bank's result memory and streams the words out over valid/ready.
// Optional ROW_LAST_EN adds out_row_last and replaces the linear address counter with row/col counters.
module conv_result_reader #(
    parameter int unsigned CONV_NUM = 2,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned OUT_ROWS = 4,
    parameter int unsigned OUT_COLS = 4,
    localparam int unsigned FILT_W  = (CONV_NUM > 1) ? $clog2(CONV_NUM) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                mem_re,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [CONV_NUM-1:0] mem_sel,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [FILT_W-1:0]   out_filter,
    output logic                out_last,
    output logic                busy,
`ifdef ROW_LAST_EN
    output logic                out_row_last,
`endif
    output logic                read_done
);

    localparam int unsigned N = OUT_ROWS * OUT_COLS;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_LAT  = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    logic [2:0]          state, state_nxt;
    logic [FILT_W-1:0]   bank_cnt, bank_nxt;
    logic [ADDR_W-1:0]   cur_addr, nxt_addr;
    logic                last_word, last_bank;

    logic                mem_re_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [CONV_NUM-1:0] mem_sel_nxt;
    logic [DATA_W-1:0]   out_data_nxt;
    logic                out_valid_nxt;
    logic [FILT_W-1:0]   out_filter_nxt;
    logic                out_last_nxt;
    logic                busy_nxt;
    logic                read_done_nxt;

`ifdef ROW_LAST_EN
    logic [ADDR_W-1:0]   row_cnt, row_nxt, col_cnt, col_nxt;
    logic                out_row_last_nxt;

    assign cur_addr = row_cnt * ADDR_W'(OUT_COLS) + col_cnt;
`else
    logic [ADDR_W-1:0]   addr_cnt, addr_nxt;

    assign cur_addr = addr_cnt;
`endif

    assign last_word = (cur_addr == ADDR_W'(N - 1));
    assign last_bank = (bank_cnt == FILT_W'(CONV_NUM - 1));

    // Next-state, counter and output-register values
    always_comb begin
        state_nxt      = state;
        bank_nxt       = bank_cnt;
        mem_re_nxt     = 1'b0;
        out_data_nxt   = out_data;
        out_valid_nxt  = out_valid;
        out_filter_nxt = out_filter;
        out_last_nxt   = out_last;
        busy_nxt       = busy;
        read_done_nxt  = 1'b0;
`ifdef ROW_LAST_EN
        row_nxt          = row_cnt;
        col_nxt          = col_cnt;
        out_row_last_nxt = out_row_last;
`else
        addr_nxt         = addr_cnt;
`endif

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt  = S_RD;
                    bank_nxt   = '0;
                    mem_re_nxt = 1'b1;
                    busy_nxt   = 1'b1;
`ifdef ROW_LAST_EN
                    row_nxt    = '0;
                    col_nxt    = '0;
`else
                    addr_nxt   = '0;
`endif
                end
            end
            S_RD: begin
                state_nxt = S_LAT;
            end
            S_LAT: begin
                state_nxt      = S_OUT;
                out_data_nxt   = mem_rdata;
                out_valid_nxt  = 1'b1;
                out_filter_nxt = bank_cnt;
                out_last_nxt   = last_word;
`ifdef ROW_LAST_EN
                out_row_last_nxt = (col_cnt == ADDR_W'(OUT_COLS - 1));
`endif
            end
            S_OUT: begin
                if (out_valid && out_ready) begin
                    out_valid_nxt = 1'b0;
                    out_last_nxt  = 1'b0;
`ifdef ROW_LAST_EN
                    out_row_last_nxt = 1'b0;
`endif
                    if (!last_word) begin
                        state_nxt  = S_RD;
                        mem_re_nxt = 1'b1;
`ifdef ROW_LAST_EN
                        if (col_cnt == ADDR_W'(OUT_COLS - 1)) begin
                            col_nxt = '0;
                            row_nxt = row_cnt + ADDR_W'(1);
                        end else begin
                            col_nxt = col_cnt + ADDR_W'(1);
                        end
`else
                        addr_nxt = addr_cnt + ADDR_W'(1);
`endif
                    end else if (!last_bank) begin
                        state_nxt  = S_RD;
                        mem_re_nxt = 1'b1;
                        bank_nxt   = bank_cnt + FILT_W'(1);
`ifdef ROW_LAST_EN
                        row_nxt    = '0;
                        col_nxt    = '0;
`else
                        addr_nxt   = '0;
`endif
                    end else begin
                        state_nxt     = S_FIN;
                        read_done_nxt = 1'b1;
                        busy_nxt      = 1'b0;
                    end
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Memory request is launched from the counters' next values so it lines up with RD
    always_comb begin
`ifdef ROW_LAST_EN
        nxt_addr = row_nxt * ADDR_W'(OUT_COLS) + col_nxt;
`else
        nxt_addr = addr_nxt;
`endif
        mem_addr_nxt = mem_re_nxt ? nxt_addr : '0;
        mem_sel_nxt  = mem_re_nxt ? (CONV_NUM'(1) << bank_nxt) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bank_cnt   <= '0;
            mem_re     <= 1'b0;
            mem_addr   <= '0;
            mem_sel    <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_filter <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            read_done  <= 1'b0;
`ifdef ROW_LAST_EN
            row_cnt      <= '0;
            col_cnt      <= '0;
            out_row_last <= 1'b0;
`else
            addr_cnt     <= '0;
`endif
        end else begin
            state      <= state_nxt;
            bank_cnt   <= bank_nxt;
            mem_re     <= mem_re_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_sel    <= mem_sel_nxt;
            out_data   <= out_data_nxt;
            out_valid  <= out_valid_nxt;
            out_filter <= out_filter_nxt;
            out_last   <= out_last_nxt;
            busy       <= busy_nxt;
            read_done  <= read_done_nxt;
`ifdef ROW_LAST_EN
            row_cnt      <= row_nxt;
            col_cnt      <= col_nxt;
            out_row_last <= out_row_last_nxt;
`else
            addr_cnt     <= addr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_conv_result_reader.sv
// Directed bench for conv_result_reader: full read-outs, backpressure, spurious start and mid-stream reset.
module tb_conv_result_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mem_re;
    logic [7:0] mem_addr;
    logic [1:0] mem_sel;
    logic [7:0] mem_rdata;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [0:0] out_filter;
    logic       out_last;
    logic       busy;
    logic       read_done;
`ifdef ROW_LAST_EN
    logic       out_row_last;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    conv_result_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mem_re     (mem_re),
        .mem_addr   (mem_addr),
        .mem_sel    (mem_sel),
        .mem_rdata  (mem_rdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_filter (out_filter),
        .out_last   (out_last),
        .busy       (busy),
`ifdef ROW_LAST_EN
        .out_row_last (out_row_last),
`endif
        .read_done  (read_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Result memory: bank b word a holds 16*b+a, one-cycle read latency, junk when not read
    always @(posedge clk) begin
        if (mem_re) begin
            case (mem_sel)
                2'b01:   mem_rdata <= 8'h00 + mem_addr;
                2'b10:   mem_rdata <= 8'h10 + mem_addr;
                default: mem_rdata <= 8'hE0;
            endcase
        end else begin
            mem_rdata <= 8'hEE;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One read-out of 32 words; optional stall, spurious start, or reset at a given word index
    task automatic readout(input int stall_w, input int start_w, input int rst_w, input bit chk_time);
        int c_prev;
        int n;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_mem_re", 32'(mem_re), 32'd1);
        chk("start_addr", 32'(mem_addr), 32'd0);
        chk("start_sel", 32'(mem_sel), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        c_prev = cyc - 1;
        for (int w = 0; w < 32; w++) begin
            n = 0;
            while (!out_valid && n < 10) begin
                step();
                n++;
            end
            chk("valid_timeout", 32'(out_valid), 32'd1);
            if (!out_valid) return;
            chk($sformatf("data_w%0d", w), 32'(out_data), 32'(w));
            chk($sformatf("filter_w%0d", w), 32'(out_filter), 32'(w / 16));
            chk($sformatf("last_w%0d", w), 32'(out_last), 32'((w % 16) == 15));
`ifdef ROW_LAST_EN
            chk($sformatf("row_last_w%0d", w), 32'(out_row_last), 32'((w % 4) == 3));
`endif
            chk($sformatf("busy_w%0d", w), 32'(busy), 32'd1);
            if (chk_time) chk($sformatf("spacing_w%0d", w), 32'(cyc - c_prev), 32'd3);
            c_prev = cyc;
            if (w == rst_w) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk("rst_valid", 32'(out_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_mem_re", 32'(mem_re), 32'd0);
                chk("rst_done", 32'(read_done), 32'd0);
                for (int k = 0; k < 6; k++) begin
                    step();
                    chk("post_rst_quiet", 32'({read_done, out_valid, mem_re, busy}), 32'd0);
                end
                return;
            end
            if (w == stall_w) begin
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    step();
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_data", 32'(out_data), 32'(w));
                    chk("stall_mem_re", 32'(mem_re), 32'd0);
                end
                out_ready = 1'b1;
            end
            if (w == start_w) start = 1'b1;
            if (w == 31 || stall_w >= 0 && w == stall_w) c_prev = cyc;
            step();
            start = 1'b0;
            if (w == stall_w) c_prev = cyc - 1;
        end
        chk("done_pulse", 32'(read_done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(out_valid), 32'd0);
        step();
        chk("done_clear", 32'(read_done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_mem_re", 32'(mem_re), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_outputs", 32'({mem_re, mem_addr, mem_sel, out_data, out_valid, out_filter,
                                out_last, busy, read_done}), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        step();
        chk("idle_no_re", 32'(mem_re), 32'd0);
        chk("idle_sel", 32'(mem_sel), 32'd0);

        // Full stream, out_ready held high, 3-cycle cadence
        readout(-1, -1, -1, 1'b1);
        step();
        // Backpressure on word 7
        readout(7, -1, -1, 1'b0);
        step();
        // Spurious start at word 10
        readout(-1, 10, -1, 1'b0);
        step();
        // Reset at word 20, then a clean replay from bank 0 address 0
        readout(-1, -1, 20, 1'b0);
        readout(-1, -1, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
